// File: rtl/rr_arb_lock_if.sv
// Request/grant bundle between the requesters and one output-port arbiter.
// master drives req/tail/en and observes the grant; slave is the arbiter side.
interface rr_arb_lock_if #(
  parameter int N = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  tail;
  logic          en;
  logic [N-1:0]  gnt;
  logic          gnt_vld;
  logic [IW-1:0] gnt_idx;
  logic          locked;
  logic [IW-1:0] owner;
  logic          timeout;

  modport master (
    output req, tail, en,
    input  gnt, gnt_vld, gnt_idx, locked, owner, timeout
  );

  modport slave (
    input  req, tail, en,
    output gnt, gnt_vld, gnt_idx, locked, owner, timeout
  );
endinterface

// File: rtl/rr_arb_lock.sv
// Round-robin output-port arbiter with wormhole packet lock and lock timeout; grant is zero-cycle.
// en low withholds the grant and freezes ptr/ownership, while the hold timer keeps counting.
module rr_arb_lock #(
  parameter int N        = 4,
  parameter int LOCK_EN  = 1,
  parameter int MAX_HOLD = 0
) (
  input logic          clk,
  input logic          reset,
  rr_arb_lock_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [15:0] HOLD_LAST = 16'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

  logic [0:0]    st;
  logic [IW-1:0] ptr;
  logic [IW-1:0] own;
  logic [15:0]   hold_cnt;
  logic          timeout_q;

  logic [N-1:0]  hi_mask;
  logic [N-1:0]  req_hi;
  logic [IW-1:0] win_lo;
  logic [IW-1:0] win_hi;
  logic [IW-1:0] winner;
  logic          any_lo;
  logic          any_hi;
  logic          arb_gnt;
  logic          lock_gnt;
  logic          grant;
  logic [IW-1:0] sel_idx;
  logic          tail_rel;
  logic          expire;

  // Rotating priority: requests at or above ptr win first, otherwise wrap to the lowest set bit.
  always_comb begin
    hi_mask = '0;
    win_lo  = '0;
    win_hi  = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = (IW'(i) >= ptr);
    end
    req_hi = bus.req & hi_mask;
    any_lo = |bus.req;
    any_hi = |req_hi;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[i]) win_lo = IW'(i);
      if (req_hi[i])  win_hi = IW'(i);
    end
    winner = any_hi ? win_hi : win_lo;
  end

  assign arb_gnt  = reset && bus.en && (st == ST_ARB) && any_lo;
  assign lock_gnt = reset && bus.en && (st == ST_LOCKED) && bus.req[own];
  assign grant    = arb_gnt || lock_gnt;
  assign sel_idx  = lock_gnt ? own : winner;
  assign tail_rel = lock_gnt && bus.tail[own];
  assign expire   = (MAX_HOLD != 0) && (st == ST_LOCKED) && !tail_rel && (hold_cnt == HOLD_LAST);

  assign bus.gnt     = grant ? (N'(1) << sel_idx) : '0;
  assign bus.gnt_vld = grant;
  assign bus.gnt_idx = grant ? sel_idx : '0;
  assign bus.locked  = (st == ST_LOCKED);
  assign bus.owner   = own;
  assign bus.timeout = timeout_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= ST_ARB;
      ptr       <= '0;
      own       <= '0;
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (st == ST_ARB) begin
        if (arb_gnt) begin
          ptr <= (winner == IW'(N - 1)) ? '0 : winner + IW'(1);
          if ((LOCK_EN != 0) && !bus.tail[winner]) begin
            st       <= ST_LOCKED;
            own      <= winner;
            hold_cnt <= '0;
          end
        end
      end else if (tail_rel) begin
        st       <= ST_ARB;
        own      <= '0;
        hold_cnt <= '0;
      end else if (expire) begin
        st        <= ST_ARB;
        own       <= '0;
        hold_cnt  <= '0;
        timeout_q <= 1'b1;
      end else if (MAX_HOLD != 0) begin
        // Bubbles and en-low cycles still age the lock.
        hold_cnt <= hold_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_rr_arb_lock.sv
// Four arbiter configurations driven by shared stimulus; a queue-based scoreboard checks every cycle.
module tb_rr_arb_lock;
  typedef logic [3:0][10:0] vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] tail = '0;
  logic       en = 1'b0;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  vec_t exp_q[$];

  int n_a[4]  = '{4, 3, 4, 4};
  int lk_a[4] = '{0, 0, 1, 1};
  int mh_a[4] = '{0, 0, 0, 4};

  int m_ptr[4];
  int m_own[4];
  int m_cnt[4];
  bit m_lck[4];
  bit m_to[4];

  always #5 clk = ~clk;

  rr_arb_lock_if #(.N(4)) if0 ();
  rr_arb_lock_if #(.N(3)) if1 ();
  rr_arb_lock_if #(.N(4)) if2 ();
  rr_arb_lock_if #(.N(4)) if3 ();

  assign if0.req = req;       assign if0.tail = tail;       assign if0.en = en;
  assign if1.req = req[2:0];  assign if1.tail = tail[2:0];  assign if1.en = en;
  assign if2.req = req;       assign if2.tail = tail;       assign if2.en = en;
  assign if3.req = req;       assign if3.tail = tail;       assign if3.en = en;

  rr_arb_lock #(.N(4), .LOCK_EN(0), .MAX_HOLD(0)) u0 (.clk(clk), .reset(reset), .bus(if0));
  rr_arb_lock #(.N(3), .LOCK_EN(0), .MAX_HOLD(0)) u1 (.clk(clk), .reset(reset), .bus(if1));
  rr_arb_lock #(.N(4), .LOCK_EN(1), .MAX_HOLD(0)) u2 (.clk(clk), .reset(reset), .bus(if2));
  rr_arb_lock #(.N(4), .LOCK_EN(1), .MAX_HOLD(4)) u3 (.clk(clk), .reset(reset), .bus(if3));

  // Reference: outputs for this cycle from the current abstract state, then advance it.
  task automatic model(input int d, input logic rst_v, input logic [3:0] r, input logic [3:0] t,
                       input logic e, output logic [10:0] x);
    int n;
    int g;
    int o;
    logic [3:0] gv;
    n = n_a[d];
    if (!rst_v) begin
      m_ptr[d] = 0; m_own[d] = 0; m_cnt[d] = 0; m_lck[d] = 1'b0; m_to[d] = 1'b0;
      x = '0;
      return;
    end
    g = -1;
    o = m_own[d];
    if (m_lck[d]) begin
      if (e && r[o[1:0]]) g = o;
    end else if (e) begin
      for (int k = 0; k < n; k++) begin
        int i;
        i = (m_ptr[d] + k) % n;
        if (g < 0 && r[i[1:0]]) g = i;
      end
    end
    gv = (g >= 0) ? 4'(1 << g) : 4'b0;
    x  = {gv, (g >= 0), 2'((g >= 0) ? g : 0), m_lck[d], 2'(o), m_to[d]};
    m_to[d] = 1'b0;
    if (m_lck[d]) begin
      if (g >= 0 && t[o[1:0]]) begin
        m_lck[d] = 1'b0; m_own[d] = 0;
      end else if (mh_a[d] != 0) begin
        m_cnt[d] = m_cnt[d] + 1;
        if (m_cnt[d] == mh_a[d]) begin
          m_lck[d] = 1'b0; m_own[d] = 0; m_to[d] = 1'b1;
        end
      end
    end else if (g >= 0) begin
      m_ptr[d] = (g + 1) % n;
      if (lk_a[d] != 0 && !t[g[1:0]]) begin
        m_lck[d] = 1'b1; m_own[d] = g; m_cnt[d] = 0;
      end
    end
  endtask

  task automatic step(input logic rst_v, input logic [3:0] r, input logic [3:0] t, input logic e);
    vec_t v;
    logic [10:0] x;
    @(negedge clk);
    reset = rst_v;
    req   = r;
    tail  = t;
    en    = e;
    for (int d = 0; d < 4; d++) begin
      model(d, rst_v, r, t, e, x);
      v[d] = x;
    end
    exp_q.push_back(v);
  endtask

  // Monitor: sample between edges and compare against the oldest expectation.
  initial begin
    vec_t v;
    vec_t act;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        v = exp_q.pop_front();
        act[0] = {if0.gnt, if0.gnt_vld, if0.gnt_idx, if0.locked, if0.owner, if0.timeout};
        act[1] = {1'b0, if1.gnt, if1.gnt_vld, if1.gnt_idx, if1.locked, if1.owner, if1.timeout};
        act[2] = {if2.gnt, if2.gnt_vld, if2.gnt_idx, if2.locked, if2.owner, if2.timeout};
        act[3] = {if3.gnt, if3.gnt_vld, if3.gnt_idx, if3.locked, if3.owner, if3.timeout};
        for (int d = 0; d < 4; d++) begin
          n_cmp++;
          if (act[d] !== v[d]) begin
            n_fail++;
            $display("FAIL dut%0d cycle %0d gnt/vld/idx/locked/owner/timeout: got %b, expected %b",
                     d, cyc, act[d], v[d]);
          end
        end
        cyc++;
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic [3:0] t;
    step(1'b0, 4'b1111, 4'b0000, 1'b1);
    step(1'b0, 4'b1111, 4'b0000, 1'b1);
    repeat (8) step(1'b1, 4'b1111, 4'b1111, 1'b1);
    // 3-flit packet from requester 0 while 1 also requests.
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 4'b0011, 4'b0000, 1'b1);
    step(1'b1, 4'b0011, 4'b0000, 1'b1);
    step(1'b1, 4'b0011, 4'b0001, 1'b1);
    step(1'b1, 4'b0011, 4'b0011, 1'b1);
    // Bubble in owner 1's packet while requester 2 waits.
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 4'b0010, 4'b0000, 1'b1);
    step(1'b1, 4'b0100, 4'b0000, 1'b1);
    step(1'b1, 4'b0100, 4'b0000, 1'b1);
    step(1'b1, 4'b0110, 4'b0010, 1'b1);
    step(1'b1, 4'b0100, 4'b0100, 1'b1);
    // Owner 2 never sends a tail: hold timeout on the MAX_HOLD instance.
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 4'b0100, 4'b0000, 1'b1);
    repeat (7) step(1'b1, 4'b1100, 4'b0000, 1'b1);
    step(1'b1, 4'b1100, 4'b1100, 1'b0);
    step(1'b1, 4'b1100, 4'b1100, 1'b1);
    // Reset asserted mid-packet while locked on owner 3.
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 4'b1000, 4'b0000, 1'b1);
    step(1'b1, 4'b1000, 4'b0000, 1'b1);
    step(1'b0, 4'b1000, 4'b0000, 1'b1);
    step(1'b1, 4'b1001, 4'b1111, 1'b1);
    step(1'b1, 4'b1001, 4'b1111, 1'b1);
    repeat (600) begin
      r = 4'($urandom);
      t = 4'($urandom) & 4'($urandom);
      step(($urandom_range(0, 99) != 0), r, t, ($urandom_range(0, 3) != 0));
    end
    @(negedge clk);
    #4;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
